particle_serial_link_tx: RTL and testbench
==========================================

Name: particle_serial_link_tx

Overview:
Per-link transmitter that feeds one serial neighbor link between particle bins during motion update. It accepts whole particle words (position/velocity payload, DATA_WIDTH bits) over a valid/ready handshake and buffers them in a 2-entry FIFO. It serializes each word LSB-first onto a 1-bit line with a frame-valid strobe, and starts a frame only when the neighbor bin advertises input availability. Six instances, one per neighbor, sit between the local bin's outgoing router and the inter-bin serial links.

Parameters:
DATA_WIDTH, 160, bits per particle word (one frame); must be >= 2 and <= 2^CNT_WIDTH.
CNT_WIDTH, 8, width of the bit-position counter.
GAP_CYCLES, 1, minimum idle cycles with serial_data_valid=0 between frames; must be >= 1.
FRAME_CNT_WIDTH, 16, width of the sent-frame counter.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
particle_data_in  input  DATA_WIDTH  parallel particle word to send.
particle_data_in_valid  input  1  word on particle_data_in is valid.
particle_data_in_ready  output  1  FIFO can accept a word (= not full).
neighbor_input_available  input  1  neighbor bin can take a particle.
serial_data_out  output  1  serialized bit; bit i of the word is driven in the i-th cycle of a frame.
serial_data_valid  output  1  high for exactly DATA_WIDTH consecutive cycles per frame.
tx_busy  output  1  high while a frame or the post-frame gap is in progress, or the FIFO is non-empty.
frames_sent  output  FRAME_CNT_WIDTH  count of completed frames; wraps.

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO emptied, FSM=IDLE, all counters 0. Every output is 0 except particle_data_in_ready, which is 1. Reset mid-frame aborts the frame at once: valid drops the same instant and the partial word is discarded and never resent.
- Handshake: a push occurs on an edge where valid && ready. particle_data_in_ready = ~full and is driven from registers, never from neighbor_input_available.
- FIFO: depth 2. A simultaneous push and pop keeps the occupancy unchanged. No push is possible when full. A pop occurs only at frame start.
- FSM states:
  - IDLE: if the FIFO is non-empty and neighbor_input_available=1 on an edge, pop the head into the shift register, set bit_cnt=0 and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: serial_data_valid=1 and serial_data_out=shift_reg[0]. Each edge shifts right and increments bit_cnt. On the edge where bit_cnt=DATA_WIDTH-1, go to GAP (or IDLE when GAP_CYCLES is 0, which is disallowed) and increment frames_sent.
  - GAP: serial_data_valid=0 and serial_data_out=0 for GAP_CYCLES cycles, then go to IDLE.
- Availability is sampled only in IDLE. Deassertion mid-frame does not stall or abort the frame.
- Latency: a word pushed on edge k into an empty FIFO, with available=1 and FSM in IDLE, drives bit 0 with valid=1 from edge k+1. The last bit is driven from edge k+DATA_WIDTH. Valid is low from edge k+DATA_WIDTH+1. The earliest next frame starts at edge k+DATA_WIDTH+1+GAP_CYCLES.
- All outputs are registered. serial_data_out is 0 whenever valid=0.
- frames_sent wraps from 2^FRAME_CNT_WIDTH-1 to 0.

Test Plan:
1. DATA_WIDTH=8, GAP_CYCLES=1, available=1; push 0xA5 on edge k -> valid high on edges k+1..k+8, with serial bits 1,0,1,0,0,1,0,1; valid=0 at edge k+9; frames_sent=1.
2. Push 0x3C and 0xFF back-to-back, with available=1 throughout -> ready stays 1 for the second push; frames are separated by exactly 1 idle cycle; frames_sent=2.
3. available=0 and 3 pushes attempted -> the first 2 are accepted, ready=0 on the third and it is held; serial_data_valid stays 0. Raise available -> the 3 frames go out in order.
4. Drop available at bit 3 of a frame -> the frame completes all 8 bits unchanged, and the next frame waits until available=1.
5. Assert rst_n=0 at bit 4 of a frame with one word queued -> valid/out go 0 immediately, ready=1, frames_sent=0; after release nothing is transmitted until a new push.
6. Set frames_sent to 0xFFFF by sending 65535 frames (or use FRAME_CNT_WIDTH=2 and send 4 frames) -> the counter wraps to 0.

Source files
------------

// File: rtl/particle_serial_link_tx.sv
`default_nettype none
// ============================================================================
//  Module   : particle_serial_link_tx
//  Purpose  : Per-link transmitter between particle bins. Whole particle
//             words are accepted over a valid/ready handshake into a
//             2-entry FIFO. Each word is then serialized LSB-first onto a
//             1-bit line with a frame-valid strobe. A frame starts only
//             when the neighbor bin advertises that it can take a particle.
//             Every frame is followed by a guaranteed idle gap.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH      bits per particle word / frame (2 .. 2**CNT_WIDTH)
//    CNT_WIDTH       width of the bit-position counter
//    GAP_CYCLES      idle cycles (valid low) after each frame, >= 1
//    FRAME_CNT_WIDTH width of the wrapping sent-frame counter
//  Ports
//    clk                      in   clock, rising edge
//    rst_n                    in   asynchronous active-low reset
//    particle_data_in         in   parallel particle word
//    particle_data_in_valid   in   word on particle_data_in is valid
//    particle_data_in_ready   out  FIFO not full (registered)
//    neighbor_input_available in   neighbor bin can accept a particle
//    serial_data_out          out  serialized bit, 0 whenever valid is low
//    serial_data_valid        out  high for DATA_WIDTH cycles per frame
//    tx_busy                  out  frame/gap in progress or FIFO non-empty
//    frames_sent              out  count of completed frames (wraps)
// ============================================================================
module particle_serial_link_tx #(
  parameter int DATA_WIDTH      = 160,
  parameter int CNT_WIDTH       = 8,
  parameter int GAP_CYCLES      = 1,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      particle_data_in,
  input  logic                       particle_data_in_valid,
  output logic                       particle_data_in_ready,
  input  logic                       neighbor_input_available,
  output logic                       serial_data_out,
  output logic                       serial_data_valid,
  output logic                       tx_busy,
  output logic [FRAME_CNT_WIDTH-1:0] frames_sent
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_WIDTH-1:0]       c_LAST_BIT  = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0]           c_LAST_GAP  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [1:0]                 c_FIFO_FULL = 2'd2;
  localparam logic [FRAME_CNT_WIDTH-1:0] c_FRAME_ONE = FRAME_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // FIFO storage and control
  logic [DATA_WIDTH-1:0]      r_mem [2];
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_count;
  logic                       r_ready;

  // Serializer / FSM
  state_t                     r_state;
  logic [DATA_WIDTH-1:0]      r_shift;
  logic [CNT_WIDTH-1:0]       r_bit_cnt;
  logic [GAP_W-1:0]           r_gap_cnt;
  logic                       r_out;
  logic                       r_valid;
  logic                       r_busy;
  logic [FRAME_CNT_WIDTH-1:0] r_frames;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                  w_push;
  logic                  w_can_start;
  logic                  w_pop;
  logic [1:0]            w_count_nxt;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_active_nxt;

  // Ready is a registered copy of "not full", so the upstream router never
  // sees a path from neighbor_input_available to its ready input.
  assign w_push = particle_data_in_valid & r_ready;

  // A frame may start from IDLE, or directly out of the last gap cycle.
  // Starting from the last gap cycle is what lets back-to-back frames be
  // separated by exactly GAP_CYCLES idle cycles instead of GAP_CYCLES+1.
  assign w_can_start = (r_state == S_IDLE) ||
                       ((r_state == S_GAP) && (r_gap_cnt == c_LAST_GAP));

  // Availability is only looked at when a frame could start; once a frame
  // is running it always completes.
  assign w_pop = w_can_start && (r_count != 2'd0) && neighbor_input_available;

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // True when the FSM will be in SHIFT or GAP after this edge. Any SHIFT
  // cycle is followed by either more SHIFT or the gap, so SHIFT always
  // counts as active next cycle.
  assign w_active_nxt = w_pop ||
                        (r_state == S_SHIFT) ||
                        ((r_state == S_GAP) && (r_gap_cnt != c_LAST_GAP));

  // --------------------------------------------------------------------------
  // FIFO storage: no reset needed, occupancy is tracked by the control regs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= particle_data_in;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control, ready and busy flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != c_FIFO_FULL);
      r_busy  <= w_active_nxt || (w_count_nxt != 2'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Serializer state machine
  // --------------------------------------------------------------------------
  // r_out/r_valid always describe the bit currently on the line. On the
  // start edge bit 0 goes straight to r_out and the shift register holds the
  // remaining bits, so r_shift[0] is always the next bit to send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      r_frames  <= '0;
    end else if (w_pop) begin
      r_state   <= S_SHIFT;
      r_shift   <= w_head >> 1;
      r_out     <= w_head[0];
      r_valid   <= 1'b1;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_bit_cnt == c_LAST_BIT) begin
            // Last bit has been on the line for one cycle: close the frame.
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
            r_out     <= 1'b0;
            r_valid   <= 1'b0;
            r_frames  <= r_frames + c_FRAME_ONE;
          end else begin
            r_out     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + CNT_WIDTH'(1);
          end
        end

        S_GAP: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          if (r_gap_cnt == c_LAST_GAP) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        S_IDLE: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_out   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign particle_data_in_ready = r_ready;
  assign serial_data_out        = r_out;
  assign serial_data_valid      = r_valid;
  assign tx_busy                = r_busy;
  assign frames_sent            = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_particle_serial_link_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_particle_serial_link_tx
//  Purpose  : Directed self-checking bench for particle_serial_link_tx with
//             DATA_WIDTH=8, GAP_CYCLES=1 and a 2-bit frame counter so the
//             wrap of frames_sent is reached after a handful of frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_particle_serial_link_tx;

  localparam int DW  = 8;
  localparam int CW  = 4;
  localparam int GAP = 1;
  localparam int FCW = 2;

  logic           clk;
  logic           rst_n;
  logic [DW-1:0]  din;
  logic           din_valid;
  logic           din_ready;
  logic           avail;
  logic           sout;
  logic           svalid;
  logic           busy;
  logic [FCW-1:0] frames;

  int checks   = 0;
  int failures = 0;

  particle_serial_link_tx #(
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW),
    .GAP_CYCLES      (GAP),
    .FRAME_CNT_WIDTH (FCW)
  ) u_dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .particle_data_in         (din),
    .particle_data_in_valid   (din_valid),
    .particle_data_in_ready   (din_ready),
    .neighbor_input_available (avail),
    .serial_data_out          (sout),
    .serial_data_valid        (svalid),
    .tx_busy                  (busy),
    .frames_sent              (frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check bits [from..to] of a frame; the current sample must hold bit 'from'.
  task automatic expect_bits(input string tag, input logic [DW-1:0] w,
                             input int from, input int to);
    for (int i = from; i <= to; i++) begin
      chk($sformatf("%s_valid_b%0d", tag, i), {31'd0, svalid}, 32'd1);
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, sout}, {31'd0, w[i]});
      if (i < to) step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    avail     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_ready",  {31'd0, din_ready}, 32'd1);
    chk("rst_valid",  {31'd0, svalid},    32'd0);
    chk("rst_out",    {31'd0, sout},      32'd0);
    chk("rst_busy",   {31'd0, busy},      32'd0);
    chk("rst_frames", {30'd0, frames},    32'd0);
    rst_n = 1'b1;
    step();

    // ---- 1: single word 0xA5 ------------------------------------------------
    avail = 1'b1; din = 8'hA5; din_valid = 1'b1;
    step();                                   // edge k: push
    din_valid = 1'b0;
    chk("t1_valid_k", {31'd0, svalid}, 32'd0);
    chk("t1_busy_k",  {31'd0, busy},   32'd1);
    step();                                   // edge k+1: bit 0
    expect_bits("t1", 8'hA5, 0, 7);           // ends at edge k+8
    step();                                   // edge k+9: gap
    chk("t1_valid_gap", {31'd0, svalid}, 32'd0);
    chk("t1_out_gap",   {31'd0, sout},   32'd0);
    chk("t1_frames",    {30'd0, frames}, 32'd1);
    chk("t1_busy_gap",  {31'd0, busy},   32'd1);
    step();
    chk("t1_busy_idle", {31'd0, busy},   32'd0);

    // ---- 2: back-to-back 0x3C, 0xFF -----------------------------------------
    din = 8'h3C; din_valid = 1'b1;
    step();                                   // push 0x3C
    chk("t2_ready_2nd", {31'd0, din_ready}, 32'd1);
    din = 8'hFF;
    step();                                   // push 0xFF, bit 0 of 0x3C
    din_valid = 1'b0;
    expect_bits("t2a", 8'h3C, 0, 7);
    step();
    chk("t2_gap_valid", {31'd0, svalid}, 32'd0);
    step();                                   // exactly one idle cycle
    expect_bits("t2b", 8'hFF, 0, 7);
    step();
    chk("t2_frames", {30'd0, frames}, 32'd3);
    step();

    // ---- 3: backpressure with neighbor unavailable --------------------------
    avail = 1'b0;
    din = 8'h11; din_valid = 1'b1;
    step();
    chk("t3_ready_1", {31'd0, din_ready}, 32'd1);
    din = 8'h22;
    step();
    chk("t3_ready_full", {31'd0, din_ready}, 32'd0);
    din = 8'h33;
    step();
    chk("t3_ready_held", {31'd0, din_ready}, 32'd0);
    chk("t3_valid_wait", {31'd0, svalid},    32'd0);
    chk("t3_busy_wait",  {31'd0, busy},      32'd1);
    step();
    chk("t3_valid_wait2", {31'd0, svalid},   32'd0);
    avail = 1'b1;
    step();                                   // pop 0x11
    chk("t3_ready_after_pop", {31'd0, din_ready}, 32'd1);
    expect_bits("t3a", 8'h11, 0, 0);
    step();                                   // held 0x33 accepted here
    din_valid = 1'b0;
    expect_bits("t3a", 8'h11, 1, 7);
    step();
    chk("t3_gap1", {31'd0, svalid}, 32'd0);
    step();
    expect_bits("t3b", 8'h22, 0, 7);
    step();
    step();
    expect_bits("t3c", 8'h33, 0, 7);
    step();
    chk("t3_frames", {30'd0, frames}, 32'd2);
    step();

    // ---- 5: reset mid-frame with a queued word ------------------------------
    din = 8'h77; din_valid = 1'b1;
    step();
    din = 8'h88;
    step();
    din_valid = 1'b0;
    expect_bits("t5", 8'h77, 0, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_valid",  {31'd0, svalid},    32'd0);
    chk("t5_out",    {31'd0, sout},      32'd0);
    chk("t5_ready",  {31'd0, din_ready}, 32'd1);
    chk("t5_frames", {30'd0, frames},    32'd0);
    chk("t5_busy",   {31'd0, busy},      32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_quiet_valid%0d", i), {31'd0, svalid}, 32'd0);
      chk($sformatf("t5_quiet_busy%0d", i),  {31'd0, busy},   32'd0);
    end

    // ---- 4: availability dropped mid-frame ----------------------------------
    din = 8'h55; din_valid = 1'b1;
    step();
    din = 8'h66;
    step();
    din_valid = 1'b0;
    expect_bits("t4a", 8'h55, 0, 2);
    avail = 1'b0;
    step();
    expect_bits("t4a", 8'h55, 3, 7);
    step();
    chk("t4_gap", {31'd0, svalid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_hold_valid%0d", i), {31'd0, svalid}, 32'd0);
      chk($sformatf("t4_hold_busy%0d", i),  {31'd0, busy},   32'd1);
    end
    avail = 1'b1;
    step();
    expect_bits("t4b", 8'h66, 0, 7);
    step();
    chk("t4_frames", {30'd0, frames}, 32'd2);
    step();

    // ---- 6: frames_sent wraps 3 -> 0 ----------------------------------------
    din = 8'hAA; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    expect_bits("t6a", 8'hAA, 0, 7);
    step();
    chk("t6_frames_max", {30'd0, frames}, 32'd3);
    step();
    din = 8'h01; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    expect_bits("t6b", 8'h01, 0, 7);
    step();
    chk("t6_frames_wrap", {30'd0, frames}, 32'd0);
    step();
    chk("t6_busy_end", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
